// File: rtl/dac_win_pkg.sv
// Shared types, edge-select codes and packed-vector helpers for the
// DAC window discriminator.
package dac_win_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_TRACK   = 2'b01,
      ST_REFRACT = 2'b10
   } state_e;

   localparam logic [1:0] EDGE_OFF   = 2'b00;
   localparam logic [1:0] EDGE_ENTER = 2'b01;
   localparam logic [1:0] EDGE_LEAVE = 2'b10;
   localparam logic [1:0] EDGE_BOTH  = 2'b11;

   // Bit offset of field k in a packed per-window vector (k = 0 in the LSBs).
   function automatic int field_lsb(input int k, input int width);
      return k * width;
   endfunction

   function automatic logic edge_hit(input logic [1:0] sel, input logic in_now,
                                     input logic in_prev);
      case (sel)
         EDGE_OFF:   return 1'b0;
         EDGE_ENTER: return in_now & ~in_prev;
         EDGE_LEAVE: return ~in_now & in_prev;
         EDGE_BOTH:  return in_now ^ in_prev;
         default:    return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dac_win_check.sv
// One time/amplitude window: match on the current sample, sticky satisfied
// flag, and detection of a window that has passed without being satisfied.
module dac_win_check
   import dac_win_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clear_i,
   input  logic              load_i,
   input  logic              upd_i,
   input  logic [CNT_W-1:0]  idx_i,
   input  logic              en_i,
   input  logic [CNT_W-1:0]  start_i,
   input  logic [CNT_W-1:0]  stop_i,
   input  logic [DATA_W-1:0] lo_i,
   input  logic [DATA_W-1:0] hi_i,
   input  logic [DATA_W-1:0] sample_i,
   output logic              flag_o,
   output logic              flag_now_o,
   output logic              late_o
);
   logic armed;
   logic match;
   logic flag_q, flag_d;

   // Disabled or inverted windows never constrain the decision.
   assign armed = en_i && (start_i <= stop_i);
   assign match = armed && (idx_i >= start_i) && (idx_i <= stop_i)
                  && (sample_i >= lo_i) && (sample_i <= hi_i);

   // A trigger sample discards whatever the previous event left behind.
   assign flag_now_o = !armed || match || (flag_q && !load_i);
   assign late_o     = armed && (idx_i > stop_i) && !flag_now_o;

   always_comb begin
      flag_d = flag_q;
      if (clear_i) begin
         flag_d = 1'b0;
      end else if (load_i || upd_i) begin
         flag_d = flag_now_o;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         flag_q <= 1'b0;
      end else begin
         flag_q <= flag_d;
      end
   end

   assign flag_o = flag_q;

endmodule

// File: rtl/dac_window_discriminator.sv
// Threshold-triggered spike discriminator for one DAC channel: N_WIN
// time/amplitude windows must all be satisfied by the decision sample.
module dac_window_discriminator
   import dac_win_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int N_WIN  = 4,
   parameter int CNT_W  = 16
) (
   input  logic                    dataclk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    sample_valid,
   input  logic [DATA_W-1:0]       sample_in,
   input  logic [DATA_W-1:0]       thresh,
   input  logic                    thresh_pol,
   input  logic [1:0]              edge_type,
   input  logic [N_WIN-1:0]        win_en,
   input  logic [N_WIN*CNT_W-1:0]  win_start,
   input  logic [N_WIN*CNT_W-1:0]  win_stop,
   input  logic [N_WIN*DATA_W-1:0] win_lo,
   input  logic [N_WIN*DATA_W-1:0] win_hi,
   input  logic [CNT_W-1:0]        stop_max,
   input  logic [CNT_W-1:0]        hold_samples,
   input  logic [CNT_W-1:0]        refract_samples,
   output logic                    hit,
   output logic                    hit_hold,
   output logic                    reject,
   output logic [1:0]              fsm_state,
   output logic [N_WIN-1:0]        win_flags,
   output logic [CNT_W-1:0]        sample_cnt
);
   state_e           state_q, state_d;
   logic             prev_q, prev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
   logic             hit_q, hit_d;
   logic             reject_q, reject_d;

   logic             in_region, trig, load, upd, eval;
   logic             decide, accept, rejecting;
   logic [CNT_W-1:0] idx;
   logic [N_WIN-1:0] flag_now, late;

   assign in_region = thresh_pol ? (sample_in >= thresh) : (sample_in <= thresh);
   assign trig      = edge_hit(edge_type, in_region, prev_q);
   assign load      = sample_valid && enable && (state_q == ST_IDLE) && trig;
   assign upd       = sample_valid && enable && (state_q == ST_TRACK);
   assign eval      = load || upd;
   // cnt_q holds the index of the last evaluated sample; the trigger is index 0.
   assign idx       = load ? '0 : cnt_q + CNT_W'(1);
   assign decide    = eval && (idx == stop_max);
   assign accept    = decide && (&flag_now) && !(|late);
   assign rejecting = eval && ((|late) || (decide && !(&flag_now)));

   for (genvar gi = 0; gi < N_WIN; gi++) begin : g_win
      localparam int CL = field_lsb(gi, CNT_W);
      localparam int DL = field_lsb(gi, DATA_W);
      dac_win_check #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_chk (
         .clk_i      (dataclk),
         .rst_i      (reset),
         .clear_i    (!enable),
         .load_i     (load),
         .upd_i      (upd),
         .idx_i      (idx),
         .en_i       (win_en[gi]),
         .start_i    (win_start[CL +: CNT_W]),
         .stop_i     (win_stop[CL +: CNT_W]),
         .lo_i       (win_lo[DL +: DATA_W]),
         .hi_i       (win_hi[DL +: DATA_W]),
         .sample_i   (sample_in),
         .flag_o     (win_flags[gi]),
         .flag_now_o (flag_now[gi]),
         .late_o     (late[gi])
      );
   end

   always_ff @(posedge dataclk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:    if (load) state_d = (accept || rejecting) ? ST_REFRACT : ST_TRACK;
            ST_TRACK:   if (accept || rejecting) state_d = ST_REFRACT;
            ST_REFRACT: if (sample_valid && (ref_cnt_q == '0)) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      prev_d     = sample_valid ? in_region : prev_q;
      cnt_d      = cnt_q;
      hold_cnt_d = hold_cnt_q;
      ref_cnt_d  = ref_cnt_q;
      hit_d      = accept;
      reject_d   = rejecting;
      if (!enable) begin
         cnt_d      = '0;
         hold_cnt_d = '0;
         ref_cnt_d  = '0;
      end else begin
         if (eval) cnt_d = idx;
         if (accept) begin
            hold_cnt_d = hold_samples;
         end else if (sample_valid && (hold_cnt_q != '0)) begin
            hold_cnt_d = hold_cnt_q - CNT_W'(1);
         end
         if (accept || rejecting) begin
            ref_cnt_d = refract_samples;
         end else if ((state_q == ST_REFRACT) && sample_valid && (ref_cnt_q != '0)) begin
            ref_cnt_d = ref_cnt_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge dataclk) begin
      if (reset) begin
         prev_q     <= 1'b0;
         cnt_q      <= '0;
         hold_cnt_q <= '0;
         ref_cnt_q  <= '0;
         hit_q      <= 1'b0;
         reject_q   <= 1'b0;
      end else begin
         prev_q     <= prev_d;
         cnt_q      <= cnt_d;
         hold_cnt_q <= hold_cnt_d;
         ref_cnt_q  <= ref_cnt_d;
         hit_q      <= hit_d;
         reject_q   <= reject_d;
      end
   end

   assign hit        = hit_q;
   assign reject     = reject_q;
   assign hit_hold   = hit_q || (hold_cnt_q != '0);
   assign fsm_state  = state_q;
   assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_dac_window_discriminator.sv
// Scoreboard bench: a sample-level behavioural model predicts every cycle's
// outputs; a negedge monitor pops and compares.
module tb_dac_window_discriminator;
   localparam int DW = 16;
   localparam int NW = 2;
   localparam int CW = 16;

   logic             dataclk = 1'b0;
   logic             reset = 1'b1;
   logic             enable = 1'b1;
   logic             sample_valid = 1'b0;
   logic [DW-1:0]    sample_in = '0;
   logic [DW-1:0]    thresh = '0;
   logic             thresh_pol = 1'b0;
   logic [1:0]       edge_type = 2'b01;
   logic [NW-1:0]    win_en = '0;
   logic [NW*CW-1:0] win_start = '0;
   logic [NW*CW-1:0] win_stop = '0;
   logic [NW*DW-1:0] win_lo = '0;
   logic [NW*DW-1:0] win_hi = '0;
   logic [CW-1:0]    stop_max = '0;
   logic [CW-1:0]    hold_samples = '0;
   logic [CW-1:0]    refract_samples = '0;
   logic             hit, hit_hold, reject;
   logic [1:0]       fsm_state;
   logic [NW-1:0]    win_flags;
   logic [CW-1:0]    sample_cnt;

   dac_window_discriminator #(.DATA_W(DW), .N_WIN(NW), .CNT_W(CW)) dut (
      .dataclk(dataclk), .reset(reset), .enable(enable),
      .sample_valid(sample_valid), .sample_in(sample_in),
      .thresh(thresh), .thresh_pol(thresh_pol), .edge_type(edge_type),
      .win_en(win_en), .win_start(win_start), .win_stop(win_stop),
      .win_lo(win_lo), .win_hi(win_hi), .stop_max(stop_max),
      .hold_samples(hold_samples), .refract_samples(refract_samples),
      .hit(hit), .hit_hold(hit_hold), .reject(reject),
      .fsm_state(fsm_state), .win_flags(win_flags), .sample_cnt(sample_cnt)
   );

   always #5 dataclk = ~dataclk;

   typedef struct packed {
      logic          hit;
      logic          rej;
      logic          hold;
      logic [1:0]    st;
      logic [NW-1:0] fl;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   dut_hits = 0, dut_rejs = 0, dut_busy = 0, dut_tracks = 0;
   logic [1:0] last_st = 2'b00;

   // Reference model: mode 0 idle, 1 tracking, 2 refractory.
   int        m_mode = 0, m_cnt = 0, m_ref = 0, m_hold = 0;
   bit        m_prev = 0, m_hit = 0, m_rej = 0;
   bit [NW-1:0] m_flags = '0;

   task automatic model_step(input bit v, input bit en, input bit rst, input logic [DW-1:0] s);
      bit inr, trg, ev, allset, late;
      int st, sp, lo, hi;
      m_hit = 0;
      m_rej = 0;
      if (rst) begin
         m_mode = 0; m_cnt = 0; m_ref = 0; m_hold = 0; m_prev = 0; m_flags = '0;
         return;
      end
      inr = thresh_pol ? (s >= thresh) : (s <= thresh);
      case (edge_type)
         2'b01:   trg = inr && !m_prev;
         2'b10:   trg = !inr && m_prev;
         2'b11:   trg = (inr != m_prev);
         default: trg = 0;
      endcase
      if (!en) begin
         m_mode = 0; m_cnt = 0; m_ref = 0; m_hold = 0; m_flags = '0;
         if (v) m_prev = inr;
         return;
      end
      if (!v) return;
      if (m_hold > 0) m_hold--;
      ev = 0;
      if (m_mode == 0 && trg) begin
         m_mode = 1; m_cnt = 0; m_flags = '0; ev = 1;
      end else if (m_mode == 1) begin
         m_cnt++; ev = 1;
      end else if (m_mode == 2) begin
         if (m_ref == 0) m_mode = 0;
         else m_ref--;
      end
      if (ev) begin
         allset = 1;
         late = 0;
         for (int k = 0; k < NW; k++) begin
            st = int'(win_start[k*CW +: CW]);
            sp = int'(win_stop[k*CW +: CW]);
            lo = int'(win_lo[k*DW +: DW]);
            hi = int'(win_hi[k*DW +: DW]);
            if (!win_en[k] || st > sp) m_flags[k] = 1;
            else if (m_cnt >= st && m_cnt <= sp && int'(s) >= lo && int'(s) <= hi) m_flags[k] = 1;
            if (win_en[k] && st <= sp && m_cnt > sp && !m_flags[k]) late = 1;
            allset = allset && m_flags[k];
         end
         if (late) m_rej = 1;
         else if (m_cnt == int'(stop_max)) begin
            if (allset) m_hit = 1;
            else m_rej = 1;
         end
         if (m_hit || m_rej) begin
            m_mode = 2;
            m_ref = int'(refract_samples);
         end
         if (m_hit) m_hold = int'(hold_samples);
      end
      m_prev = inr;
   endtask

   function automatic exp_t cur_exp();
      exp_t e;
      e.hit  = m_hit;
      e.rej  = m_rej;
      e.hold = m_hit || (m_hold > 0);
      e.st   = 2'(m_mode);
      e.fl   = m_flags;
      e.cnt  = CW'(m_cnt);
      return e;
   endfunction

   task automatic tick(input bit v, input logic [DW-1:0] s);
      sample_valid = v;
      sample_in = s;
      model_step(v, enable, reset, s);
      @(posedge dataclk);
      exp_q.push_back(cur_exp());
      #1;
   endtask

   task automatic feed(input int n, input logic [DW-1:0] s);
      for (int i = 0; i < n; i++) begin
         int g;
         g = int'($urandom_range(0, 2));
         for (int j = 0; j < g; j++) tick(1'b0, DW'($urandom_range(0, 65535)));
         tick(1'b1, s);
      end
   endtask

   task automatic flush(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, sample_in);
   endtask

   task automatic go_idle();
      enable = 1'b0;
      tick(1'b0, sample_in);
      enable = 1'b1;
      tick(1'b0, sample_in);
   endtask

   task automatic check_eq(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end else begin
         $display("check %s: %0d ok", name, act);
      end
   endtask

   task automatic set_common();
      thresh = 16'd32255;
      thresh_pol = 1'b0;
      edge_type = 2'b01;
      win_en = 2'b11;
      win_start = {16'd4, 16'd0};
      win_stop = {16'd8, 16'd2};
      win_lo = {16'd33000, 16'd0};
      win_hi = {16'd65535, 16'd32255};
      stop_max = 16'd8;
      hold_samples = 16'd10;
      refract_samples = 16'd2;
   endtask

   always @(negedge dataclk) begin
      exp_t e, a;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         a = {hit, reject, hit_hold, fsm_state, win_flags, sample_cnt};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL cycle_state t=%0t: got hit=%b rej=%b hold=%b st=%b flags=%b cnt=%0d, expected hit=%b rej=%b hold=%b st=%b flags=%b cnt=%0d",
                     $time, a.hit, a.rej, a.hold, a.st, a.fl, a.cnt, e.hit, e.rej, e.hold, e.st, e.fl, e.cnt);
         end else if (hit || reject) begin
            $display("event t=%0t hit=%b reject=%b flags=%b cnt=%0d", $time, hit, reject, win_flags, sample_cnt);
         end
         if (hit) dut_hits++;
         if (reject) dut_rejs++;
         if (fsm_state != 2'b00) dut_busy++;
         if (fsm_state == 2'b01 && last_st != 2'b01) dut_tracks++;
         last_st = fsm_state;
      end
   end

   initial begin
      int h0, r0, b0, t0;
      set_common();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) tick(1'b0, 16'd0);
      check_eq("reset_outputs", int'({hit, reject, hit_hold, fsm_state, win_flags, sample_cnt}), 0);
      reset = 1'b0;

      // accept
      go_idle(); h0 = dut_hits; r0 = dut_rejs;
      feed(3, 16'd32767); feed(1, 16'd32000); feed(1, 16'd31500); feed(1, 16'd32500);
      feed(1, 16'd32800); feed(1, 16'd33500); feed(20, 16'd32768); flush(3);
      check_eq("accept_hits", dut_hits - h0, 1);
      check_eq("accept_rejects", dut_rejs - r0, 0);

      // early reject: second window never satisfied
      go_idle(); h0 = dut_hits; r0 = dut_rejs;
      feed(2, 16'd32767); feed(14, 16'd32000); flush(3);
      check_eq("early_rej_hits", dut_hits - h0, 0);
      check_eq("early_rej_rejects", dut_rejs - r0, 1);

      // window miss at index 1
      win_start[15:0] = 16'd1; win_stop[15:0] = 16'd1;
      go_idle(); r0 = dut_rejs;
      feed(2, 16'd32767); feed(1, 16'd32000); feed(1, 16'd32500); feed(4, 16'd32767); flush(3);
      check_eq("miss_rejects", dut_rejs - r0, 1);

      // refractory window blocks an early retrigger but not a later one
      set_common(); refract_samples = 16'd5;
      go_idle(); r0 = dut_rejs; t0 = dut_tracks;
      feed(2, 16'd32767); feed(9, 16'd32000);
      feed(2, 16'd32767); feed(1, 16'd32000); feed(3, 16'd32767); feed(1, 16'd32000);
      feed(12, 16'd32767); flush(3);
      check_eq("refract_tracks", dut_tracks - t0, 2);
      check_eq("refract_rejects", dut_rejs - r0, 2);

      // edge_type off
      set_common(); edge_type = 2'b00;
      go_idle(); b0 = dut_busy;
      for (int i = 0; i < 30; i++) feed(1, DW'($urandom_range(30000, 35000)));
      flush(2);
      check_eq("edge_off_busy", dut_busy - b0, 0);

      // stop_max = 0, no windows: decision on trigger sample
      set_common(); win_en = 2'b00; stop_max = 16'd0;
      go_idle(); h0 = dut_hits;
      feed(2, 16'd32767); feed(1, 16'd32000); feed(4, 16'd32767); flush(3);
      check_eq("stop0_hits", dut_hits - h0, 1);

      // inverted second window is forced satisfied
      set_common(); win_start[31:16] = 16'd6; win_stop[31:16] = 16'd3;
      go_idle(); h0 = dut_hits;
      feed(2, 16'd32767); feed(12, 16'd32000); flush(3);
      check_eq("inverted_hits", dut_hits - h0, 1);

      // reset mid-track
      set_common();
      go_idle();
      feed(2, 16'd32767); feed(5, 16'd32000);
      reset = 1'b1; tick(1'b0, 16'd32000); reset = 1'b0;
      check_eq("midtrack_reset", int'({hit, reject, hit_hold, fsm_state, win_flags, sample_cnt}), 0);
      feed(12, 16'd32000); flush(3);

      // enable low mid-track cancels the event
      go_idle(); h0 = dut_hits;
      feed(2, 16'd32767); feed(1, 16'd32000); feed(1, 16'd31500); feed(1, 16'd32500);
      enable = 1'b0; tick(1'b1, 16'd32800); enable = 1'b1;
      feed(1, 16'd33500); feed(12, 16'd32768); flush(3);
      check_eq("enable_drop_hits", dut_hits - h0, 0);

      // randomized configurations and samples
      for (int r = 0; r < 12; r++) begin
         thresh = DW'($urandom_range(31500, 34500));
         thresh_pol = 1'($urandom_range(0, 1));
         edge_type = 2'($urandom_range(0, 3));
         win_en = NW'($urandom_range(0, 3));
         for (int k = 0; k < NW; k++) begin
            int lo;
            lo = int'($urandom_range(30000, 34000));
            win_start[k*CW +: CW] = CW'($urandom_range(0, 12));
            win_stop[k*CW +: CW] = CW'($urandom_range(0, 12));
            win_lo[k*DW +: DW] = DW'(lo);
            win_hi[k*DW +: DW] = DW'(lo + int'($urandom_range(0, 4000)));
         end
         stop_max = CW'($urandom_range(0, 14));
         hold_samples = CW'($urandom_range(0, 5));
         refract_samples = CW'($urandom_range(0, 5));
         go_idle();
         for (int i = 0; i < 150; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            enable = ($urandom_range(0, 59) != 0);
            tick($urandom_range(0, 9) < 7, DW'($urandom_range(31000, 35000)));
         end
         reset = 1'b0;
         enable = 1'b1;
      end
      flush(3);
      @(negedge dataclk); #1;
      check_eq("scoreboard_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
